// File: rtl/karat_div.sv
// Sequential radix-2 restoring divider: 2W-bit dividend by W-bit divisor.
// Valid/ready on both sides; error cases short-circuit from CHECK to DONE.
module karat_div #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   C,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_dz;
    logic                r_ov;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_r;
    logic [2*WIDTH-1:0]  r_c;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_qsh;
    logic [CW-1:0]       r_cnt;

    logic [WIDTH:0]      w_sh;
    logic                w_ge;
    logic [WIDTH-1:0]    w_rem_nx;
    logic [WIDTH-1:0]    w_qsh_nx;

    // rem < B always, so the shifted value needs one extra bit only for the compare
    assign w_sh     = {r_rem, r_qsh[WIDTH-1]};
    assign w_ge     = (w_sh >= {1'b0, r_b});
    assign w_rem_nx = w_ge ? (w_sh[WIDTH-1:0] - r_b) : w_sh[WIDTH-1:0];
    assign w_qsh_nx = {r_qsh[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_qsh       <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_c        <= C;
                        r_b        <= B;
                        r_dz       <= 1'b0;
                        r_ov       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_b == '0) begin
                        r_q         <= '1;
                        r_r         <= r_c[WIDTH-1:0];
                        r_dz        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_c[2*WIDTH-1:WIDTH] >= r_b) begin
                        r_q         <= '1;
                        r_r         <= '0;
                        r_ov        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_rem   <= r_c[2*WIDTH-1:WIDTH];
                        r_qsh   <= r_c[WIDTH-1:0];
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_qsh <= w_qsh_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_q         <= w_qsh_nx;
                        r_r         <= w_rem_nx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule

// File: doc/karat_div.md
Name: karat_div

Overview:
- Sequential radix-2 restoring divider, the inverse of the karat 16x16 multiplier: takes a 32-bit product-width dividend C and a 16-bit divisor B, returns 16-bit quotient Q and remainder R.
- Sits beside karat in the arithmetic datapath and is used for modular reduction and for round-trip checking of multiplier results (C / B == A).
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; the dividend is 2*WIDTH bits wide and a division takes WIDTH iteration cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands present on C and B
- in_ready  out  1  divider can accept operands
- C  in  2*WIDTH  dividend
- B  in  WIDTH  divisor
- out_valid  out  1  result valid on Q, R and the flags
- out_ready  in  1  consumer accepts the result
- Q  out  WIDTH  quotient
- R  out  WIDTH  remainder
- div_by_zero  out  1  B was 0
- overflow  out  1  quotient does not fit in WIDTH bits (C[2W-1:W] >= B, B != 0)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: when rst_n is low at a clock edge, the state goes to IDLE from any state, including mid-division or while holding a result. Q, R, out_valid, div_by_zero, overflow and busy go to 0; in_ready is 1 from the first post-reset cycle.
- States are IDLE, CHECK, DIV and DONE.
- IDLE: in_ready is 1. On an edge with in_valid=1, C and B are captured (accept edge) and the state goes to CHECK. Later changes on C or B are ignored until the next accept.
- CHECK, one cycle:
  - If B==0: Q=all-ones, R=C[W-1:0], div_by_zero=1, state goes to DONE.
  - Else if C[2W-1:W] >= B: Q=all-ones, R=0, overflow=1, state goes to DONE.
  - Else: the remainder register (W+1 bits) is loaded with C[2W-1:W], the quotient shift register with C[W-1:0], the iteration counter with 0, and the state goes to DIV.
- DIV, exactly WIDTH cycles. Each cycle:
  - {rem,qsh} is shifted left by 1.
  - If the shifted rem >= B, B is subtracted from rem and qsh[0] is set to 1; otherwise qsh[0] is 0.
  - After the WIDTH-th iteration, Q=qsh, R=rem[W-1:0], and the state goes to DONE.
  - rem < B holds throughout, so W+1 bits are sufficient.
- DONE: out_valid=1. Q, R and the flags are held stable while out_ready=0. On an edge with out_ready=1, the state goes to IDLE and out_valid drops; the flags clear at the next accept.
- in_ready is 0 in CHECK, DIV and DONE. in_valid asserted there is ignored, not queued.
- Latency from the accept edge to out_valid high:
  - normal divide: WIDTH+2 edges (18 for WIDTH=16);
  - error cases: 2 edges.
- Throughput: one result per WIDTH+3 cycles when out_ready is held high.
- div_by_zero and overflow are never both 1.

Test Plan:
- Exact divide. C=2074 (34*61), B=61 -> out_valid exactly 18 cycles after accept, Q=34, R=0, both flags 0.
- Remainder. C=2075, B=61 -> Q=34, R=1.
- Maximum exact divide. C=32'hFFFE0001, B=16'hFFFF -> Q=16'hFFFF, R=0, no overflow.
- Error cases:
  - C=32'h12345678, B=0 -> at 2 cycles: div_by_zero=1, Q=16'hFFFF, R=16'h5678.
  - C=32'h00010000, B=1 -> at 2 cycles: overflow=1, Q=16'hFFFF, R=0.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles after out_valid -> Q, R and out_valid stay stable.
  - Pulse in_valid during DIV -> ignored, the original result is unchanged.
  - Release out_ready -> in_ready returns the next cycle.
- Reset mid-operation. Drive rst_n=0 at iteration 8 of C=2074, B=61 -> next cycle IDLE with all outputs 0 and in_ready=1. A new request C=100, B=7 then gives Q=14, R=2.
